i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/i2s_transmitter.sv | 128 ++++++++++++
 tb/tb_i2s_transmitter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S serial transmitter: a small sample FIFO feeds one sample per 64-slot frame,
// sent MSB-first with a one-bit delay on both channels; sticky overflow/underrun flags.
module i2s_transmitter #(
  parameter int DATA_WIDTH = 32,
  parameter int I2S_WIDTH  = 24,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [DATA_WIDTH-1:0]        audio_in,
  input  logic                                data_in_valid,
  input  logic                                clear_flags,
  output logic                                i2s_sclk,
  output logic                                i2s_lrclk,
  output logic                                i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
  output logic                                overflow,
  output logic                                underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [DW-1:0]         div;
  logic [5:0]            bit_cnt;
  logic [5:0]            bit_nxt;
  logic [4:0]            slot;
  logic [DATA_WIDTH-1:0] tx_sample;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sdata_nxt;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;

  logic tick, fall, wrap;
  logic empty, full;
  logic push, pop, drop, under_set;

  assign tick      = (div == DW'(SCLK_DIV - 1));
  assign fall      = tick && i2s_sclk;
  assign wrap      = fall && (bit_cnt == 6'd63);

  // Occupancy is sampled before this cycle's push, so a push into an empty
  // FIFO on the wrap cycle cannot be popped in the same cycle.
  assign empty     = (count == '0);
  assign full      = (count == LW'(FIFO_DEPTH));
  assign pop       = wrap && !empty;
  assign under_set = wrap && empty;
  assign push      = data_in_valid && (!full || pop);
  assign drop      = data_in_valid && full && !pop;

  assign bit_nxt    = bit_cnt + 6'd1;
  assign slot       = bit_nxt[4:0];
  assign fifo_level = count;

  // tx_sample[DATA_WIDTH-p] is the MSB of the sample shifted left by p-1.
  always_comb begin
    shifted   = tx_sample << (slot - 5'd1);
    sdata_nxt = 1'b0;
    if (slot != 5'd0 && slot <= 5'(I2S_WIDTH)) begin
      sdata_nxt = shifted[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      i2s_sclk  <= 1'b0;
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      if (tick) begin
        div      <= '0;
        i2s_sclk <= ~i2s_sclk;
      end else begin
        div <= div + DW'(1);
      end
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[5];
        i2s_sdata <= sdata_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tx_sample <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        tx_sample <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= audio_in;
  end

  // A set event in the same cycle as clear_flags wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (under_set)        underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: table-driven FIFO/flag vectors, then frame-level
// checks of the serial stream captured on every sclk fall.
module tb_i2s_transmitter;

  localparam int DATA_WIDTH = 32;
  localparam int I2S_WIDTH  = 24;
  localparam int SCLK_DIV   = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic signed [DATA_WIDTH-1:0] audio_in = '0;
  logic        data_in_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic        i2s_sclk, i2s_lrclk, i2s_sdata;
  logic [2:0]  fifo_level;
  logic        overflow, underrun;

  int checks = 0;
  int errors = 0;

  i2s_transmitter #(
    .DATA_WIDTH(DATA_WIDTH), .I2S_WIDTH(I2S_WIDTH),
    .SCLK_DIV(SCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .audio_in(audio_in), .data_in_valid(data_in_valid),
    .clear_flags(clear_flags), .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .fifo_level(fifo_level), .overflow(overflow),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Frame monitor: its own slot counter tracks bit_cnt from reset.
  logic        prev_sclk = 1'b0;
  logic [5:0]  mon_cnt = '0;
  logic [63:0] sd_rec = '0, lr_rec = '0, sd_frame = '0, lr_frame = '0;
  int          frames_done = 0;
  int          cyc = 0, last_fall = 0, period = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      prev_sclk = 1'b0;
      mon_cnt   = '0;
      sd_rec    = '0;
      lr_rec    = '0;
    end else begin
      if (prev_sclk && !i2s_sclk) begin
        mon_cnt = mon_cnt + 6'd1;
        sd_rec[mon_cnt] = i2s_sdata;
        lr_rec[mon_cnt] = i2s_lrclk;
        period    = cyc - last_fall;
        last_fall = cyc;
        if (mon_cnt == 6'd63) begin
          sd_frame    = sd_rec;
          lr_frame    = lr_rec;
          frames_done = frames_done + 1;
        end
      end
      prev_sclk = i2s_sclk;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [31:0] s);
    logic [63:0] f;
    int p;
    f = '0;
    for (int k = 0; k < 64; k++) begin
      p = k % 32;
      if (p >= 1 && p <= I2S_WIDTH) f[k] = s[32-p];
    end
    return f;
  endfunction

  task automatic wait_frame(input string name);
    int start;
    bit got;
    start = frames_done;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (frames_done != start) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: frame not completed within 400 cycles", name);
    end
  endtask

  task automatic wait_slot(input string name, input logic [5:0] target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (mon_cnt == target) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: slot %0d not reached within 400 cycles", name, target);
    end
  endtask

  task automatic push_one(input logic [31:0] d);
    audio_in = d;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic        clear;
    logic [31:0] data;
    logic [2:0]  lvl;
    logic        ovf;
    logic        unr;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] frame_samp[6];
  logic [2:0]  frame_lvl[6];
  logic        frame_unr[6];
  logic [63:0] lr_exp;

  initial begin
    lr_exp = 64'hFFFF_FFFF_0000_0000;
    //              rst  vld clr data           lvl ovf unr
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h80000000, 3'd2, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h7FFFFFFF, 3'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h12345678, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 3'd4, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h55555555, 3'd4, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 3'd4, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 32'h0,        3'd4, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h0,        3'd4, 1'b0, 1'b0};

    frame_samp = '{32'h0, 32'hDEADBEEF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678, 32'h12345678};
    frame_lvl  = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    frame_unr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #1;
    chk("reset_sclk", 64'(i2s_sclk), 64'd0);
    chk("reset_lrclk", 64'(i2s_lrclk), 64'd0);
    chk("reset_sdata", 64'(i2s_sdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // FIFO fill, overflow and clear_flags, far from the first frame wrap
    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst;
      data_in_valid = vecs[i].valid;
      clear_flags = vecs[i].clear;
      audio_in = vecs[i].data;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(vecs[i].lvl));
      chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_underrun", i), 64'(underrun), 64'(vecs[i].unr));
    end
    data_in_valid = 1'b0;
    clear_flags = 1'b0;

    // Reset frame, four popped samples, then an underrun repeat
    for (int f = 0; f < 6; f++) begin
      wait_frame($sformatf("frame%0d_wait", f));
      chk($sformatf("frame%0d_sdata", f), sd_frame, exp_frame(frame_samp[f]));
      chk($sformatf("frame%0d_lrclk", f), lr_frame, lr_exp);
      chk($sformatf("frame%0d_level", f), 64'(fifo_level), 64'(frame_lvl[f]));
      chk($sformatf("frame%0d_underrun", f), 64'(underrun), 64'(frame_unr[f]));
      chk($sformatf("frame%0d_sclk_period", f), 64'(period), 64'(2 * SCLK_DIV));
    end

    // clear_flags with no coincident event
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    chk("clear_underrun", 64'(underrun), 64'd0);
    chk("clear_overflow", 64'(overflow), 64'd0);

    // Next wrap finds the FIFO empty again; then load three samples mid-frame
    wait_slot("slot10_wait", 6'd10);
    chk("underrun_again", 64'(underrun), 64'd1);
    push_one(32'h11111111);
    push_one(32'h22222222);
    push_one(32'h33333333);
    chk("midframe_level", 64'(fifo_level), 64'd3);

    // Asynchronous reset at bit_cnt=40
    wait_slot("slot40_wait", 6'd40);
    rst = 1'b1;
    #1;
    chk("rst_mid_sclk", 64'(i2s_sclk), 64'd0);
    chk("rst_mid_lrclk", 64'(i2s_lrclk), 64'd0);
    chk("rst_mid_sdata", 64'(i2s_sdata), 64'd0);
    chk("rst_mid_level", 64'(fifo_level), 64'd0);
    chk("rst_mid_underrun", 64'(underrun), 64'd0);
    chk("rst_mid_overflow", 64'(overflow), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_level", 64'(fifo_level), 64'd0);

    wait_frame("post_rst_frame_wait");
    chk("post_rst_frame_sdata", sd_frame, exp_frame(32'h0));
    chk("post_rst_frame_lrclk", lr_frame, lr_exp);
    chk("post_rst_underrun", 64'(underrun), 64'd0);

    // Push landing exactly on the wrap while empty: underrun set, sample kept
    repeat (2) @(posedge clk);
    #1;
    audio_in = 32'h00C0FFEE;
    data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    chk("wrap_push_underrun", 64'(underrun), 64'd1);
    chk("wrap_push_level", 64'(fifo_level), 64'd1);

    wait_frame("late_frame_wait");
    chk("late_frame_sdata", sd_frame, exp_frame(32'h0));
    wait_frame("stored_frame_wait");
    chk("stored_frame_sdata", sd_frame, exp_frame(32'h00C0FFEE));
    chk("stored_frame_level", 64'(fifo_level), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
